controle_multiciclo: RTL and testbench

- Multicycle control FSM that sits directly upstream of the register bank.
- Drives the 4-bit `estado` code and the `regiwrite`/`memtoreg` pair the bank samples. Write-back happens only in states 0110 (ALU result) and 0111 (memory data).
- Sequences fetch/decode/execute/memory/write-back per RV32I instruction class. Issues datapath strobes, handshakes with data memory, counts retired instructions.

---
 rtl/controle_multiciclo.sv | 230 +++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// handshakes with data memory and counts retired instructions. Define ILLEGAL_TRAP_EN to trap unknown opcodes.
module controle_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 fim,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  output logic [3:0]           estado,
  output logic                 regiwrite,
  output logic                 memtoreg,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrc,
  output logic [1:0]           aluop,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 branch,
  output logic                 halted,
  output logic                 erro,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned RD_W   = 5;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'b0000,
    S_FETCH     = 4'b0001,
    S_DECODE    = 4'b0010,
    S_EXEC      = 4'b0011,
    S_MEM_ADDR  = 4'b0100,
    S_MEM_READ  = 4'b0101,
    S_WB_ALU    = 4'b0110,
    S_WB_MEM    = 4'b0111,
    S_MEM_WRITE = 4'b1000,
    S_BRANCH    = 4'b1001,
    S_HALT      = 4'b1010
  } state_t;

  state_t              state, state_nxt;
  logic [OP_W-1:0]     opcode, opcode_nxt;
  logic [RD_W-1:0]     rd, rd_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                retire;
  logic                erro_set;

  logic                regiwrite_nxt, memtoreg_nxt, memread_nxt, memwrite_nxt;
  logic                alusrc_nxt, irwrite_nxt, pcwrite_nxt, branch_nxt, halted_nxt;
  logic [1:0]          aluop_nxt;

  // Only opcode and rd fields are consumed here.
  logic unused_instr;
  assign unused_instr = ^{instr[31:12]};

  assign estado = state;

  // Next-state, latched-field and retire decode.
  always_comb begin
    state_nxt    = state;
    opcode_nxt   = opcode;
    rd_nxt       = rd;
    wait_cnt_nxt = wait_cnt;
    retire       = 1'b0;
    erro_set     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        opcode_nxt = instr[6:0];
        rd_nxt     = instr[11:7];
        case (instr[6:0])
          OP_R, OP_I:        state_nxt = S_EXEC;
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt = S_HALT;
            erro_set  = 1'b1;
`else
            retire    = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC: begin
        state_nxt = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        wait_cnt_nxt = '0;
        state_nxt    = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ, S_MEM_WRITE: begin
        // A ready on the final allowed cycle still completes the access.
        if (mem_ready) begin
          wait_cnt_nxt = '0;
          if (state == S_MEM_READ) state_nxt = S_WB_MEM;
          else                     retire    = 1'b1;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = S_HALT;
          erro_set  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        retire = 1'b1;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_HALT;
        erro_set  = 1'b1;
      end
    endcase

    if (retire) state_nxt = fim ? S_HALT : S_FETCH;

    count_nxt = instr_count;
    if (retire && !(&instr_count)) count_nxt = instr_count + CNT_WIDTH'(1);
  end

  // Strobes decoded from the upcoming state so the registered copies track estado.
  always_comb begin
    regiwrite_nxt = 1'b0;
    memtoreg_nxt  = 1'b0;
    memread_nxt   = 1'b0;
    memwrite_nxt  = 1'b0;
    alusrc_nxt    = 1'b0;
    aluop_nxt     = ALU_ADD;
    irwrite_nxt   = 1'b0;
    pcwrite_nxt   = 1'b0;
    branch_nxt    = 1'b0;
    halted_nxt    = 1'b0;

    case (state_nxt)
      S_FETCH: begin
        irwrite_nxt = 1'b1;
        pcwrite_nxt = 1'b1;
      end
      S_EXEC: begin
        aluop_nxt  = ALU_FUNCT;
        alusrc_nxt = (opcode_nxt == OP_I);
      end
      S_MEM_ADDR: begin
        aluop_nxt  = ALU_ADD;
        alusrc_nxt = 1'b1;
      end
      S_MEM_READ:  memread_nxt  = 1'b1;
      S_MEM_WRITE: memwrite_nxt = 1'b1;
      S_WB_ALU: begin
        regiwrite_nxt = (rd_nxt != '0);
        memtoreg_nxt  = 1'b0;
      end
      S_WB_MEM: begin
        regiwrite_nxt = (rd_nxt != '0);
        memtoreg_nxt  = 1'b1;
      end
      S_BRANCH: begin
        aluop_nxt  = ALU_SUB;
        alusrc_nxt = 1'b0;
        branch_nxt = 1'b1;
      end
      S_HALT: halted_nxt = 1'b1;
      default: ;
    endcase
  end

  // FSM, latched fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      opcode      <= '0;
      rd          <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      erro        <= 1'b0;
      regiwrite   <= 1'b0;
      memtoreg    <= 1'b0;
      memread     <= 1'b0;
      memwrite    <= 1'b0;
      alusrc      <= 1'b0;
      aluop       <= ALU_ADD;
      irwrite     <= 1'b0;
      pcwrite     <= 1'b0;
      branch      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      opcode      <= opcode_nxt;
      rd          <= rd_nxt;
      wait_cnt    <= wait_cnt_nxt;
      instr_count <= count_nxt;
      erro        <= erro | erro_set;
      regiwrite   <= regiwrite_nxt;
      memtoreg    <= memtoreg_nxt;
      memread     <= memread_nxt;
      memwrite    <= memwrite_nxt;
      alusrc      <= alusrc_nxt;
      aluop       <= aluop_nxt;
      irwrite     <= irwrite_nxt;
      pcwrite     <= pcwrite_nxt;
      branch      <= branch_nxt;
      halted      <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: R/I, load, store, branch, timeout, reset and unknown opcode.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n, start, fim, mem_ready;
  logic [31:0] instr;
  logic [3:0]  estado;
  logic        regiwrite, memtoreg, memread, memwrite, alusrc, irwrite, pcwrite, branch, halted, erro;
  logic [1:0]  aluop;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Strobe vector: {regiwrite,memtoreg,memread,memwrite,alusrc,aluop[1:0],irwrite,pcwrite,branch,halted,erro}
  localparam logic [11:0] X_NONE   = 12'h000;
  localparam logic [11:0] X_FETCH  = 12'h018;
  localparam logic [11:0] X_EXEC_R = 12'h040;
  localparam logic [11:0] X_EXEC_I = 12'h0C0;
  localparam logic [11:0] X_MADDR  = 12'h080;
  localparam logic [11:0] X_MREAD  = 12'h200;
  localparam logic [11:0] X_MWRITE = 12'h100;
  localparam logic [11:0] X_WBALU  = 12'h800;
  localparam logic [11:0] X_WBMEM  = 12'hC00;
  localparam logic [11:0] X_BR     = 12'h024;
  localparam logic [11:0] X_HALT   = 12'h002;
  localparam logic [11:0] X_HALTE  = 12'h003;

  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fim(fim), .instr(instr), .mem_ready(mem_ready),
    .estado(estado), .regiwrite(regiwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .alusrc(alusrc), .aluop(aluop), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .halted(halted), .erro(erro), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp_st, input logic [11:0] exp_strb);
    chk({tag, ".estado"}, 32'(estado), 32'(exp_st));
    chk({tag, ".strobes"}, 32'({regiwrite, memtoreg, memread, memwrite, alusrc, aluop,
                               irwrite, pcwrite, branch, halted, erro}), 32'(exp_strb));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fim = 1'b0; mem_ready = 1'b0; instr = 32'h0;
    step(); step();
    chk_out("reset", 4'h0, X_NONE);
    chk("reset.count", instr_count, 32'd0);

    // add x3,x1,x2
    rst_n = 1'b1; start = 1'b1; instr = 32'h002081B3;
    step(); chk_out("add.fetch", 4'h1, X_FETCH); start = 1'b0;
    step(); chk_out("add.decode", 4'h2, X_NONE);
    step(); chk_out("add.exec", 4'h3, X_EXEC_R);
    step(); chk_out("add.wb", 4'h6, X_WBALU);
    step(); chk_out("add.refetch", 4'h1, X_FETCH);
    chk("add.count", instr_count, 32'd1);

    // lw x3,0(x1) with three wait cycles
    instr = 32'h0000A183;
    step(); chk_out("lw.decode", 4'h2, X_NONE);
    step(); chk_out("lw.addr", 4'h4, X_MADDR);
    step(); chk_out("lw.read0", 4'h5, X_MREAD);
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("lw.readwait", 4'h5, X_MREAD);
    end
    mem_ready = 1'b1;
    step(); chk_out("lw.wb", 4'h7, X_WBMEM); mem_ready = 1'b0;
    step(); chk_out("lw.refetch", 4'h1, X_FETCH);
    chk("lw.count", instr_count, 32'd2);

    // addi x0,x0,0: write-back suppressed but still retires
    instr = 32'h00000013;
    step(); chk_out("addi.decode", 4'h2, X_NONE);
    step(); chk_out("addi.exec", 4'h3, X_EXEC_I);
    step(); chk_out("addi.wb_x0", 4'h6, X_NONE);
    step(); chk_out("addi.refetch", 4'h1, X_FETCH);
    chk("addi.count", instr_count, 32'd3);

    // beq with fim=1 ends the program
    instr = 32'h00208463; fim = 1'b1;
    step(); chk_out("beq.decode", 4'h2, X_NONE);
    step(); chk_out("beq.branch", 4'h9, X_BR);
    step(); chk_out("beq.halt", 4'hA, X_HALT);
    chk("beq.count", instr_count, 32'd4);
    start = 1'b1; fim = 1'b0;
    step(); chk_out("halt.hold", 4'hA, X_HALT);
    start = 1'b0;

    // Store with ready on the last allowed wait cycle
    rst_n = 1'b0;
    step(); chk_out("rst2", 4'h0, X_NONE);
    chk("rst2.count", instr_count, 32'd0);
    rst_n = 1'b1; start = 1'b1; instr = 32'h0020A023;
    step(); chk_out("sw.fetch", 4'h1, X_FETCH); start = 1'b0;
    step(); chk_out("sw.decode", 4'h2, X_NONE);
    step(); chk_out("sw.addr", 4'h4, X_MADDR);
    step(); chk_out("sw.write0", 4'h5 + 4'h3, X_MWRITE);
    for (int i = 0; i < 15; i++) begin
      step(); chk_out("sw.wait", 4'h8, X_MWRITE);
    end
    mem_ready = 1'b1;
    step(); chk_out("sw.lastready", 4'h1, X_FETCH); mem_ready = 1'b0;
    chk("sw.count", instr_count, 32'd1);

    // Store that never completes: 16 cycles in MEM_WRITE, then error halt
    step(); chk_out("swto.decode", 4'h2, X_NONE);
    step(); chk_out("swto.addr", 4'h4, X_MADDR);
    for (int i = 0; i < 16; i++) begin
      step(); chk_out("swto.wait", 4'h8, X_MWRITE);
    end
    step(); chk_out("swto.halt", 4'hA, X_HALTE);
    chk("swto.count", instr_count, 32'd1);

    // Reset in the middle of a load wait
    rst_n = 1'b0;
    step(); rst_n = 1'b1; start = 1'b1; instr = 32'h0000A183;
    step(); start = 1'b0;
    step(); step(); step(); step();
    chk_out("lw2.wait", 4'h5, X_MREAD);
    rst_n = 1'b0;
    step(); chk_out("lw2.reset", 4'h0, X_NONE);
    chk("lw2.reset.count", instr_count, 32'd0);

    // Unknown opcode 0x7F
    rst_n = 1'b1; start = 1'b1; instr = 32'h0000007F;
    step(); chk_out("ill.fetch", 4'h1, X_FETCH); start = 1'b0;
    step(); chk_out("ill.decode", 4'h2, X_NONE);
    step();
`ifdef ILLEGAL_TRAP_EN
    chk_out("ill.trap", 4'hA, X_HALTE);
    chk("ill.count", instr_count, 32'd0);
`else
    chk_out("ill.nop", 4'h1, X_FETCH);
    chk("ill.count", instr_count, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
